// File: rtl/gear_shift_ctrl.sv
// gear_shift_ctrl: dwell-timed gear selector driven by manual and auto requests.
// A request must be held for a gear-dependent number of cycles before a shift.
// Optional feature: define GEAR_RACE_BOOST_EN to halve the upshift dwell
// (minimum 1) while boost & en is high. Without it, boost is ignored.
module gear_shift_ctrl #(
  parameter int NGEARS   = 6,
  parameter int TW       = 8,
  parameter int UP_BASE  = 8,
  parameter int UP_STEP  = 4,
  parameter int DN_DWELL = 6,
  localparam int GW      = $clog2(NGEARS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          am,
  input  logic          dm,
  input  logic          a_auto,
  input  logic          d_auto,
  input  logic          en,
  input  logic          boost,
  output logic [GW-1:0] gear,
  output logic [TW-1:0] cnt,
  output logic [1:0]    dir,
  output logic          shift_up,
  output logic          shift_dn,
  output logic          parked,
  output logic          at_top
);

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } state_t;

  localparam logic [GW-1:0] TOP     = GW'(NGEARS);
  localparam logic [TW-1:0] DN_LAST = TW'(DN_DWELL - 1);

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] gear_next;
  logic [TW-1:0] cnt_next;
  logic          su_next;
  logic          sd_next;
  logic          up;
  logic          dn;
  logic [TW-1:0] upd;
  logic [TW-1:0] upd_last;

  // Manual requests always win; an auto request only counts when enabled and
  // not contradicted by the opposite manual request.
  assign up = am | (en & a_auto & ~dm);
  assign dn = dm | (en & d_auto & ~am);

`ifdef GEAR_RACE_BOOST_EN
  logic [TW-1:0] upd_base;

  // Upshift dwell for the current gear, halved (never below 1) under boost.
  always_comb begin
    upd_base = TW'(UP_BASE) + TW'(gear) * TW'(UP_STEP);
    upd      = upd_base;
    if (boost & en) begin
      upd = upd_base >> 1;
      if (upd == '0) begin
        upd = TW'(1);
      end
    end
  end
`else
  logic unused_boost;
  assign unused_boost = boost;

  // Upshift dwell for the current gear; grows linearly with gear index.
  always_comb begin
    upd = TW'(UP_BASE) + TW'(gear) * TW'(UP_STEP);
  end
`endif

  assign upd_last = upd - TW'(1);

  // Direction decode plus dwell counting; a direction change only restarts
  // the count, the gear moves once the same direction has dwelled long enough.
  always_comb begin
    state_next = HOLD;
    gear_next  = gear;
    cnt_next   = cnt;
    su_next    = 1'b0;
    sd_next    = 1'b0;

    if (up && !dn) begin
      state_next = UP;
    end else if (dn && !up) begin
      state_next = DN;
    end

    if (state_next != state) begin
      cnt_next = '0;
    end else begin
      case (state)
        UP: begin
          if (gear == TOP) begin
            cnt_next = '0;
          end else if (cnt >= upd_last) begin
            gear_next = gear + GW'(1);
            cnt_next  = '0;
            su_next   = 1'b1;
          end else begin
            cnt_next = cnt + TW'(1);
          end
        end
        DN: begin
          if (gear == '0) begin
            cnt_next = '0;
          end else if (cnt >= DN_LAST) begin
            gear_next = gear - GW'(1);
            cnt_next  = '0;
            sd_next   = 1'b1;
          end else begin
            cnt_next = cnt + TW'(1);
          end
        end
        default: begin
          cnt_next = '0;
        end
      endcase
    end
  end

  // State, gear, count and shift pulses; reset doubles as the handbrake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      gear     <= '0;
      cnt      <= '0;
      shift_up <= 1'b0;
      shift_dn <= 1'b0;
    end else begin
      state    <= state_next;
      gear     <= gear_next;
      cnt      <= cnt_next;
      shift_up <= su_next;
      shift_dn <= sd_next;
    end
  end

  assign dir    = state;
  assign parked = (gear == '0);
  assign at_top = (gear == TOP);

endmodule
